rle_enc_param: RTL



---
 rtl/rle_enc_param.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/rle_enc_param.sv
// Run-length encoder: reads plaintext bytes from dpsram, writes {count,symbol} pairs back.
// Optional RLE_CHECKSUM_EN adds an 8-bit XOR checksum output of all processed bytes.
module rle_enc_param #(
  parameter int unsigned MAX_RUN = 255,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned SIZE_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [SIZE_W-1:0] message_size,
  input  logic [31:0]       rle_addr,
  output logic [SIZE_W-1:0] rle_size,
  output logic              busy,
  output logic              done,
`ifdef RLE_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_SCAN    = 3'd4;
  localparam logic [2:0] S_WR      = 3'd5;
  localparam logic [2:0] S_FLUSH   = 3'd6;
  localparam logic [2:0] S_FIN     = 3'd7;

  localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);

  logic [2:0]        state;
  logic [2:0]        ret_state;
  logic [31:0]       msg_ptr;
  logic [31:0]       rle_ptr;
  logic [SIZE_W-1:0] remaining;
  logic [31:0]       word;
  logic [1:0]        idx;
  logic [2:0]        nbytes;
  logic [7:0]        cur_sym;
  logic [7:0]        cur_cnt;
  logic              run_open;
  logic [15:0]       pend_lo;
  logic              pend;
  logic [31:0]       wr_data;

  logic [31:0] word_sh;
  logic [7:0]  cur_byte;
  logic        last_in_word;
  logic        frame_end;
  logic        extend;
  logic        commit;
  logic [15:0] cur_pair;
  logic [2:0]  after_byte;

  assign port_A_clk = clk;

  always_comb begin
    word_sh      = word >> {idx, 3'b000};
    cur_byte     = word_sh[7:0];
    last_in_word = ({1'b0, idx} == (nbytes - 3'd1));
    frame_end    = last_in_word && (remaining == '0);
    extend       = run_open && (cur_byte == cur_sym) && (cur_cnt < MAX_CNT);
    commit       = run_open && !extend;
    cur_pair     = {cur_cnt, cur_sym};
    after_byte   = S_SCAN;
    if (last_in_word) begin
      after_byte = frame_end ? S_FLUSH : S_RD_REQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      ret_state      <= S_IDLE;
      rle_size       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      port_A_we      <= 1'b0;
      port_A_addr    <= '0;
      port_A_data_in <= '0;
      msg_ptr        <= '0;
      rle_ptr        <= '0;
      remaining      <= '0;
      word           <= '0;
      idx            <= '0;
      nbytes         <= '0;
      cur_sym        <= '0;
      cur_cnt        <= '0;
      run_open       <= 1'b0;
      pend_lo        <= '0;
      pend           <= 1'b0;
      wr_data        <= '0;
    end else begin
      port_A_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            msg_ptr   <= message_addr & ~32'h3;
            rle_ptr   <= rle_addr & ~32'h3;
            remaining <= message_size;
            rle_size  <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            run_open  <= 1'b0;
            pend      <= 1'b0;
            state     <= (message_size == '0) ? S_FIN : S_RD_REQ;
          end
        end
        S_RD_REQ: begin
          port_A_addr <= msg_ptr[ADDR_W-1:0];
          state       <= S_RD_WAIT;
        end
        S_RD_WAIT: state <= S_LOAD;
        S_LOAD: begin
          word    <= port_A_data_out;
          idx     <= '0;
          msg_ptr <= msg_ptr + 32'd4;
          if (remaining >= SIZE_W'(4)) begin
            nbytes    <= 3'd4;
            remaining <= remaining - SIZE_W'(4);
          end else begin
            nbytes    <= remaining[2:0];
            remaining <= '0;
          end
          state <= S_SCAN;
        end
        S_SCAN: begin
          run_open <= 1'b1;
          idx      <= idx + 2'd1;
          if (extend) begin
            cur_cnt <= cur_cnt + 8'd1;
          end else begin
            cur_sym <= cur_byte;
            cur_cnt <= 8'd1;
          end
          state <= after_byte;
          if (commit) begin
            if (pend) begin
              wr_data   <= {cur_pair, pend_lo};
              pend      <= 1'b0;
              ret_state <= after_byte;
              state     <= S_WR;
            end else begin
              pend_lo <= cur_pair;
              pend    <= 1'b1;
            end
          end
        end
        S_WR: begin
          port_A_we      <= 1'b1;
          port_A_addr    <= rle_ptr[ADDR_W-1:0];
          port_A_data_in <= wr_data;
          rle_ptr        <= rle_ptr + 32'd4;
          rle_size       <= rle_size + SIZE_W'(4);
          state          <= ret_state;
        end
        S_FLUSH: begin
          // The still-open final run is committed here, merged with any pending pair.
          port_A_we   <= 1'b1;
          port_A_addr <= rle_ptr[ADDR_W-1:0];
          rle_ptr     <= rle_ptr + 32'd4;
          pend        <= 1'b0;
          if (pend) begin
            port_A_data_in <= {cur_pair, pend_lo};
            rle_size       <= rle_size + SIZE_W'(4);
          end else begin
            port_A_data_in <= {16'h0000, cur_pair};
            rle_size       <= rle_size + SIZE_W'(2);
          end
          state <= S_FIN;
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RLE_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == S_IDLE && start) begin
      checksum <= '0;
    end else if (state == S_SCAN) begin
      checksum <= checksum ^ cur_byte;
    end
  end
`endif

endmodule
